// File: rtl/udma_pattern_gen_pkg.sv
// Shared types and constants for the uDMA RX pattern generator.
// Covers the pattern modes, the FSM states and the LFSR feedback masks for each width.
package udma_pattern_gen_pkg;

    typedef enum logic [1:0] {
        MODE_INCR  = 2'd0,
        MODE_DECR  = 2'd1,
        MODE_LFSR  = 2'd2,
        MODE_CONST = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_GEN        = 2'd1,
        ST_GAP        = 2'd2,
        ST_WAIT_CLEAR = 2'd3
    } state_e;

    // Galois right-shift feedback masks.
    // Bit i of the mask is set for every tap at x^(i+1).
    function automatic logic [63:0] lfsr_taps(input int unsigned width);
        logic [63:0] taps;
        case (width)
            8:       taps = 64'h0000_0000_0000_00B8;
            16:      taps = 64'h0000_0000_0000_B400;
            24:      taps = 64'h0000_0000_00E1_0000;
            32:      taps = 64'h0000_0000_8020_0003;
            40:      taps = 64'h0000_00A0_0014_0000;
            48:      taps = 64'h0000_C000_0018_0000;
            56:      taps = 64'h00C0_0006_0000_0000;
            64:      taps = 64'hD800_0000_0000_0000;
            default: taps = (64'd1 << (width - 1)) | 64'd1;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/udma_pattern_next.sv
// Combinational next-word unit for the pattern generator.
// INCR and DECR wrap modulo 2^DATA_WIDTH; LFSR is a Galois right-shift register.
module udma_pattern_next
    import udma_pattern_gen_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  mode_e                 mode,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [DATA_WIDTH-1:0] step,
    output logic [DATA_WIDTH-1:0] next_data
);

    localparam logic [63:0]           TAPS_FULL = lfsr_taps(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] TAPS      = TAPS_FULL[DATA_WIDTH-1:0];

    always_comb begin
        next_data = data;
        case (mode)
            MODE_INCR:  next_data = data + step;
            MODE_DECR:  next_data = data - step;
            MODE_LFSR:  next_data = (data >> 1) ^ (data[0] ? TAPS : '0);
            MODE_CONST: next_data = data;
            default:    next_data = data;
        endcase
    end

endmodule

// File: rtl/udma_pattern_gen_rx.sv
// uDMA RX traffic generator: emits INCR/DECR/LFSR/CONST words on a valid/ready channel,
// with a programmable inter-word gap, a continuous mode and a done pulse at the end of each run.
module udma_pattern_gen_rx
    import udma_pattern_gen_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned GAP_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cfg_en_i,
    input  logic [1:0]            cfg_mode_i,
    input  logic [DATA_WIDTH-1:0] cfg_seed_i,
    input  logic [DATA_WIDTH-1:0] cfg_step_i,
    input  logic [CNT_WIDTH-1:0]  cfg_len_i,
    input  logic [GAP_WIDTH-1:0]  cfg_gap_i,
    input  logic                  cfg_cont_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CNT_WIDTH-1:0]  words_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    input  logic                  rx_ready_i
);

    state_e                state;
    mode_e                 mode_q;
    logic [DATA_WIDTH-1:0] seed_q;
    logic [DATA_WIDTH-1:0] step_q;
    logic [CNT_WIDTH-1:0]  len_q;
    logic [GAP_WIDTH-1:0]  gap_q;
    logic                  cont_q;

    logic [DATA_WIDTH-1:0] data_q;
    logic [CNT_WIDTH-1:0]  count_q;
    logic [GAP_WIDTH-1:0]  gap_cnt;
    logic                  valid_q;
    logic                  busy_q;
    logic                  done_q;

    logic [DATA_WIDTH-1:0] next_data;
    logic [DATA_WIDTH-1:0] seed_eff;
    logic                  beat;
    logic                  last;

    // An all-zero LFSR seed would never advance, so it is replaced by 1.
    assign seed_eff = (mode_e'(cfg_mode_i) == MODE_LFSR && cfg_seed_i == '0)
                      ? DATA_WIDTH'(1) : cfg_seed_i;
    assign beat     = valid_q & rx_ready_i;
    assign last     = (count_q == len_q);

    udma_pattern_next #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_next (
        .mode      (mode_q),
        .data      (data_q),
        .step      (step_q),
        .next_data (next_data)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            mode_q  <= MODE_INCR;
            seed_q  <= '0;
            step_q  <= '0;
            len_q   <= '0;
            gap_q   <= '0;
            cont_q  <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
            gap_cnt <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cfg_en_i) begin
                        mode_q  <= mode_e'(cfg_mode_i);
                        seed_q  <= seed_eff;
                        step_q  <= cfg_step_i;
                        len_q   <= cfg_len_i;
                        gap_q   <= cfg_gap_i;
                        cont_q  <= cfg_cont_i;
                        data_q  <= seed_eff;
                        count_q <= '0;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state   <= ST_GEN;
                    end
                end
                ST_GEN: begin
                    if (beat) begin
                        count_q <= count_q + CNT_WIDTH'(1);
                        if (!cfg_en_i) begin
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            state   <= ST_IDLE;
                        end else if (last && !cont_q) begin
                            done_q  <= 1'b1;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            state   <= ST_WAIT_CLEAR;
                        end else begin
                            // A continuous restart and a normal advance share the gap handling.
                            if (last) begin
                                done_q  <= 1'b1;
                                data_q  <= seed_q;
                                count_q <= '0;
                            end else begin
                                data_q <= next_data;
                            end
                            if (gap_q != '0) begin
                                gap_cnt <= gap_q;
                                valid_q <= 1'b0;
                                state   <= ST_GAP;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (!cfg_en_i) begin
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (gap_cnt <= GAP_WIDTH'(1)) begin
                        valid_q <= 1'b1;
                        state   <= ST_GEN;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_WIDTH'(1);
                    end
                end
                ST_WAIT_CLEAR: begin
                    if (!cfg_en_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign words_o    = count_q;
    assign rx_data_o  = data_q;
    assign rx_valid_o = valid_q;

endmodule

// File: tb/tb_udma_pattern_gen_rx.sv
// Directed bench for udma_pattern_gen_rx.
// Outputs are sampled 1 time unit after each rising edge and compared with hand-computed values.
module tb_udma_pattern_gen_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_en;
    logic [1:0]  cfg_mode;
    logic [31:0] cfg_seed;
    logic [31:0] cfg_step;
    logic [15:0] cfg_len;
    logic [7:0]  cfg_gap;
    logic        cfg_cont;
    logic        busy;
    logic        done;
    logic [15:0] words;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    udma_pattern_gen_rx #(
        .DATA_WIDTH (32),
        .CNT_WIDTH  (16),
        .GAP_WIDTH  (8)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .cfg_en_i   (cfg_en),
        .cfg_mode_i (cfg_mode),
        .cfg_seed_i (cfg_seed),
        .cfg_step_i (cfg_step),
        .cfg_len_i  (cfg_len),
        .cfg_gap_i  (cfg_gap),
        .cfg_cont_i (cfg_cont),
        .busy_o     (busy),
        .done_o     (done),
        .words_o    (words),
        .rx_data_o  (rx_data),
        .rx_valid_o (rx_valid),
        .rx_ready_i (rx_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] d,
                             input logic dn, input logic b, input logic [15:0] w);
        check({tag, ".valid"}, 64'(rx_valid), 64'(v));
        if (v) check({tag, ".data"}, 64'(rx_data), 64'(d));
        check({tag, ".done"}, 64'(done), 64'(dn));
        check({tag, ".busy"}, 64'(busy), 64'(b));
        check({tag, ".words"}, 64'(words), 64'(w));
    endtask

    logic [31:0] lfsr_exp [5];
    int          ready_pat [12];
    int          idx;

    initial begin
        lfsr_exp  = '{32'h0000_0001, 32'h8020_0003, 32'hC030_0002, 32'h6018_0001, 32'hB02C_0003};
        ready_pat = '{0, 1, 0, 0, 1, 1, 0, 1, 0, 1, 1, 1};

        rst = 1'b1; cfg_en = 1'b0; cfg_mode = 2'd0; cfg_seed = '0; cfg_step = '0;
        cfg_len = '0; cfg_gap = '0; cfg_cont = 1'b0; rx_ready = 1'b0;
        tick(); tick();
        check_out("reset", 1'b0, 32'h0, 1'b0, 1'b0, 16'd0);
        check("reset.data", 64'(rx_data), 64'h0);
        rst = 1'b0;
        tick();
        check_out("idle", 1'b0, 32'h0, 1'b0, 1'b0, 16'd0);

        // INCR seed 0x10 step 1, four words back-to-back
        cfg_mode = 2'd0; cfg_seed = 32'h10; cfg_step = 32'd1; cfg_len = 16'd3;
        cfg_gap = 8'd0; cfg_cont = 1'b0; rx_ready = 1'b1; cfg_en = 1'b1;
        tick(); check_out("incr.w0", 1'b1, 32'h10, 1'b0, 1'b1, 16'd0);
        tick(); check_out("incr.w1", 1'b1, 32'h11, 1'b0, 1'b1, 16'd1);
        tick(); check_out("incr.w2", 1'b1, 32'h12, 1'b0, 1'b1, 16'd2);
        tick(); check_out("incr.w3", 1'b1, 32'h13, 1'b0, 1'b1, 16'd3);
        tick(); check_out("incr.done", 1'b0, 32'h0, 1'b1, 1'b0, 16'd4);
        tick(); check_out("incr.wait", 1'b0, 32'h0, 1'b0, 1'b0, 16'd4);
        cfg_en = 1'b0;
        tick(); check_out("incr.idle", 1'b0, 32'h0, 1'b0, 1'b0, 16'd4);

        // DECR seed 1 step 2 wraps below zero
        cfg_mode = 2'd1; cfg_seed = 32'd1; cfg_step = 32'd2; cfg_len = 16'd2; cfg_en = 1'b1;
        tick(); check_out("decr.w0", 1'b1, 32'h0000_0001, 1'b0, 1'b1, 16'd0);
        tick(); check_out("decr.w1", 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 16'd1);
        tick(); check_out("decr.w2", 1'b1, 32'hFFFF_FFFD, 1'b0, 1'b1, 16'd2);
        tick(); check_out("decr.done", 1'b0, 32'h0, 1'b1, 1'b0, 16'd3);
        cfg_en = 1'b0;
        tick();

        // INCR with gap 2: valid high, low, low, high
        cfg_mode = 2'd0; cfg_seed = 32'h0; cfg_step = 32'd1; cfg_len = 16'd1; cfg_gap = 8'd2; cfg_en = 1'b1;
        tick(); check_out("gap.w0", 1'b1, 32'h0, 1'b0, 1'b1, 16'd0);
        tick(); check_out("gap.idle1", 1'b0, 32'h0, 1'b0, 1'b1, 16'd1);
        tick(); check_out("gap.idle2", 1'b0, 32'h0, 1'b0, 1'b1, 16'd1);
        tick(); check_out("gap.w1", 1'b1, 32'h1, 1'b0, 1'b1, 16'd1);
        tick(); check_out("gap.done", 1'b0, 32'h0, 1'b1, 1'b0, 16'd2);
        cfg_en = 1'b0;
        tick();

        // LFSR with seed 0 (forced to 1) under ready stalls
        cfg_mode = 2'd2; cfg_seed = 32'h0; cfg_len = 16'd4; cfg_gap = 8'd0; cfg_en = 1'b1;
        tick();
        idx = 0;
        for (int c = 0; c < 12 && idx < 5; c++) begin
            rx_ready = ready_pat[c][0];
            check($sformatf("lfsr.valid%0d", c), 64'(rx_valid), 64'd1);
            check($sformatf("lfsr.data%0d", c), 64'(rx_data), 64'(lfsr_exp[idx]));
            tick();
            if (ready_pat[c] != 0) idx++;
        end
        check("lfsr.count", 64'(idx), 64'd5);
        check_out("lfsr.done", 1'b0, 32'h0, 1'b1, 1'b0, 16'd5);
        cfg_en = 1'b0; rx_ready = 1'b1;
        tick();

        // Continuous mode: 5,6,5,6 with done after every second beat
        cfg_mode = 2'd0; cfg_seed = 32'd5; cfg_step = 32'd1; cfg_len = 16'd1; cfg_cont = 1'b1; cfg_en = 1'b1;
        tick(); check_out("cont.w0", 1'b1, 32'd5, 1'b0, 1'b1, 16'd0);
        cfg_seed = 32'h99;
        tick(); check_out("cont.w1", 1'b1, 32'd6, 1'b0, 1'b1, 16'd1);
        tick(); check_out("cont.w2", 1'b1, 32'd5, 1'b1, 1'b1, 16'd0);
        tick(); check_out("cont.w3", 1'b1, 32'd6, 1'b0, 1'b1, 16'd1);
        tick(); check_out("cont.w4", 1'b1, 32'd5, 1'b1, 1'b1, 16'd0);
        cfg_en = 1'b0;
        tick(); check_out("cont.abort", 1'b0, 32'h0, 1'b0, 1'b0, 16'd1);

        // Continuous with gap 1: dropping enable during the gap returns to idle
        cfg_seed = 32'd5; cfg_gap = 8'd1; cfg_en = 1'b1;
        tick(); check_out("cgap.w0", 1'b1, 32'd5, 1'b0, 1'b1, 16'd0);
        tick(); check_out("cgap.gap", 1'b0, 32'h0, 1'b0, 1'b1, 16'd1);
        cfg_en = 1'b0;
        tick(); check_out("cgap.idle", 1'b0, 32'h0, 1'b0, 1'b0, 16'd1);
        tick(); check_out("cgap.stay", 1'b0, 32'h0, 1'b0, 1'b0, 16'd1);

        // Asynchronous reset while a word is pending
        cfg_cont = 1'b0; cfg_gap = 8'd0; cfg_seed = 32'h20; cfg_len = 16'd5; rx_ready = 1'b0; cfg_en = 1'b1;
        tick(); check_out("arst.pre", 1'b1, 32'h20, 1'b0, 1'b1, 16'd0);
        #2 rst = 1'b1;
        #1;
        check_out("arst.async", 1'b0, 32'h0, 1'b0, 1'b0, 16'd0);
        check("arst.data", 64'(rx_data), 64'h0);
        cfg_en = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        cfg_en = 1'b1; rx_ready = 1'b1;
        tick(); check_out("arst.w0", 1'b1, 32'h20, 1'b0, 1'b1, 16'd0);
        tick(); check_out("arst.w1", 1'b1, 32'h21, 1'b0, 1'b1, 16'd1);
        cfg_en = 1'b0;
        tick(); check_out("arst.end", 1'b0, 32'h0, 1'b0, 1'b0, 16'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
